pwm_d2a: RTL and testbench

Digital-to-analog counterpart of the single-slope A2D. Turns a WIDTH-bit code into a fixed-period PWM waveform; an external RC filter recovers the analog level. Used to drive the A2D's analog input and in loopback checks (write code N, A2D reads back ≈N). Double-buffered duty code, so a new code only takes effect at a period boundary.

---
 rtl/pwm_d2a.sv | 119 +++++++++++
 tb/tb_pwm_d2a.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_d2a.sv
// PWM digital-to-analog converter: turns a WIDTH-bit code into a fixed
// 2^WIDTH-clock PWM waveform. The duty code is double-buffered (shadow ->
// active) so a new code only takes effect at a period boundary.
module pwm_d2a #(
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             strt,
   input  logic             stop,
   input  logic             wrt,
   input  logic [WIDTH-1:0] duty,
   output logic             PWM_sig,
   output logic             busy,
   output logic             prd_cmplt,
   output logic [WIDTH-1:0] duty_cur
);

   localparam logic [0:0]       IDLE    = 1'b0;
   localparam logic [0:0]       RUN     = 1'b1;
   localparam logic [WIDTH-1:0] CNT_MAX = '1;

   logic [0:0]       state_q,     state_d;
   logic [WIDTH-1:0] cnt_q,       cnt_d;
   logic [WIDTH-1:0] shadow_q,    shadow_d;
   logic [WIDTH-1:0] duty_cur_q,  duty_cur_d;
   logic             pwm_q,       pwm_d;
   logic             busy_q,      busy_d;
   logic             prd_q,       prd_d;
   logic             stop_pend_q, stop_pend_d;
   logic [WIDTH-1:0] eff_duty;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q       <= '0;
         shadow_q    <= '0;
         duty_cur_q  <= '0;
         pwm_q       <= 1'b0;
         busy_q      <= 1'b0;
         prd_q       <= 1'b0;
         stop_pend_q <= 1'b0;
      end else begin
         cnt_q       <= cnt_d;
         shadow_q    <= shadow_d;
         duty_cur_q  <= duty_cur_d;
         pwm_q       <= pwm_d;
         busy_q      <= busy_d;
         prd_q       <= prd_d;
         stop_pend_q <= stop_pend_d;
      end
   end

   // Next-state and next-output logic; a write on a load cycle is used at once
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      shadow_d    = shadow_q;
      duty_cur_d  = duty_cur_q;
      pwm_d       = 1'b0;
      busy_d      = busy_q;
      prd_d       = 1'b0;
      stop_pend_d = stop_pend_q;
      eff_duty    = wrt ? duty : shadow_q;

      if (wrt) begin
         shadow_d = duty;
      end

      case (state_q)
         IDLE: begin
            cnt_d       = '0;
            busy_d      = 1'b0;
            stop_pend_d = 1'b0;
            if (strt) begin
               state_d    = RUN;
               duty_cur_d = eff_duty;
               busy_d     = 1'b1;
            end
         end
         RUN: begin
            cnt_d = WIDTH'(cnt_q + 1'b1);
            pwm_d = (cnt_q < duty_cur_q);
            if (stop) begin
               stop_pend_d = 1'b1;
            end
            // Period boundary: either finish the pending stop or swap in the new code
            if (cnt_q == CNT_MAX) begin
               prd_d = 1'b1;
               if (stop_pend_q || stop) begin
                  state_d     = IDLE;
                  busy_d      = 1'b0;
                  stop_pend_d = 1'b0;
               end else begin
                  duty_cur_d = eff_duty;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign PWM_sig   = pwm_q;
   assign busy      = busy_q;
   assign prd_cmplt = prd_q;
   assign duty_cur  = duty_cur_q;

endmodule

// File: tb/tb_pwm_d2a.sv
// Directed bench for pwm_d2a: period shape, double buffering, stop, reset.
module tb_pwm_d2a;

   localparam int unsigned WIDTH = 10;
   localparam int          PER   = 1024;

   logic             clk = 1'b0;
   logic             rst;
   logic             strt;
   logic             stop;
   logic             wrt;
   logic [WIDTH-1:0] duty;
   logic             PWM_sig;
   logic             busy;
   logic             prd_cmplt;
   logic [WIDTH-1:0] duty_cur;

   int n_chk  = 0;
   int n_pass = 0;

   pwm_d2a #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .strt      (strt),
      .stop      (stop),
      .wrt       (wrt),
      .duty      (duty),
      .PWM_sig   (PWM_sig),
      .busy      (busy),
      .prd_cmplt (prd_cmplt),
      .duty_cur  (duty_cur)
   );

   always #5 clk = ~clk;

   // Advance one clock and settle just past the edge
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   // Sample one full period (samples 0..PER-1 correspond to cnt 0..PER-1),
   // optionally pulsing wrt or stop right after a given sample.
   task automatic run_period(input int wrt_at, input logic [WIDTH-1:0] wrt_val, input int stop_at,
                             output int highs, output int contig, output int pc_cnt,
                             output int pc_pos, output int mid_duty, output int mid_busy);
      logic [PER-1:0] bits;
      highs    = 0;
      pc_cnt   = 0;
      pc_pos   = -1;
      mid_duty = -1;
      mid_busy = -1;
      bits     = '0;
      for (int i = 0; i < PER; i++) begin
         tick;
         bits[i] = PWM_sig;
         if (PWM_sig === 1'b1) highs++;
         if (prd_cmplt === 1'b1) begin
            pc_cnt++;
            pc_pos = i;
         end
         if (i == 700) begin
            mid_duty = int'(duty_cur);
            mid_busy = int'(busy);
         end
         wrt  = (i == wrt_at);
         stop = (i == stop_at);
         if (i == wrt_at) duty = wrt_val;
      end
      wrt    = 1'b0;
      stop   = 1'b0;
      contig = 1;
      for (int i = 0; i < PER; i++) begin
         if (bits[i] !== 1'(i < highs)) contig = 0;
      end
   endtask

   task automatic pulse_strt;
      strt = 1'b1;
      tick;
      strt = 1'b0;
   endtask

   int h, c, pc, pp, md, mb, act;

   initial begin
      rst  = 1'b1;
      strt = 1'b0;
      stop = 1'b0;
      wrt  = 1'b0;
      duty = '0;
      repeat (3) tick;
      chk("rst_pwm", PWM_sig, 0);
      chk("rst_busy", busy, 0);
      chk("rst_prd", prd_cmplt, 0);
      chk("rst_duty_cur", duty_cur, 0);
      rst = 1'b0;
      tick;

      // Load 0x100 in IDLE, then start
      wrt  = 1'b1;
      duty = 10'h100;
      tick;
      wrt = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_duty_cur", duty_cur, 0);
      pulse_strt;
      chk("start_busy", busy, 1);
      chk("start_duty_cur", duty_cur, 10'h100);
      chk("start_pwm", PWM_sig, 0);

      run_period(-1, '0, -1, h, c, pc, pp, md, mb);
      chk("p1_highs", h, 256);
      chk("p1_contig", c, 1);
      chk("p1_prd_cnt", pc, 1);
      chk("p1_prd_pos", pp, PER - 1);

      // Mid-period write must not disturb the current period
      run_period(500, 10'h200, -1, h, c, pc, pp, md, mb);
      chk("p2_highs", h, 256);
      chk("p2_mid_duty_cur", md, 10'h100);
      chk("p2_prd_pos", pp, PER - 1);
      chk("p2_duty_cur_after_wrap", duty_cur, 10'h200);

      // Write on the wrap cycle applies to the next period
      run_period(PER - 2, 10'h000, -1, h, c, pc, pp, md, mb);
      chk("p3_highs", h, 512);
      chk("p3_contig", c, 1);
      chk("p3_duty_cur_after_wrap", duty_cur, 0);

      for (int k = 0; k < 3; k++) begin
         run_period((k == 2) ? PER - 2 : -1, 10'h3FF, -1, h, c, pc, pp, md, mb);
         chk("zero_highs", h, 0);
         chk("zero_prd_cnt", pc, 1);
         chk("zero_prd_pos", pp, PER - 1);
      end

      run_period(PER - 2, 10'h080, -1, h, c, pc, pp, md, mb);
      chk("max_highs", h, 1023);
      chk("max_contig", c, 1);
      chk("max_busy_mid", mb, 1);

      // Stop mid-period: period still completes
      run_period(-1, '0, 300, h, c, pc, pp, md, mb);
      chk("stop_highs", h, 128);
      chk("stop_contig", c, 1);
      chk("stop_prd_pos", pp, PER - 1);
      chk("stop_busy_mid", mb, 1);
      chk("stop_busy_after", busy, 0);
      act = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (PWM_sig !== 1'b0 || busy !== 1'b0 || prd_cmplt !== 1'b0) act++;
      end
      chk("stop_idle_quiet", act, 0);

      // Restart uses the retained shadow and begins from cnt=0
      pulse_strt;
      chk("restart_busy", busy, 1);
      chk("restart_duty_cur", duty_cur, 10'h080);
      run_period(PER - 2, 10'h200, -1, h, c, pc, pp, md, mb);
      chk("restart_highs", h, 128);
      chk("restart_prd_pos", pp, PER - 1);

      // Asynchronous reset during the high phase
      for (int i = 0; i <= 100; i++) tick;
      chk("pre_rst_pwm", PWM_sig, 1);
      rst = 1'b1;
      #1;
      chk("async_rst_pwm", PWM_sig, 0);
      chk("async_rst_busy", busy, 0);
      chk("async_rst_duty_cur", duty_cur, 0);
      rst = 1'b0;
      act = 0;
      for (int i = 0; i < 20; i++) begin
         tick;
         if (PWM_sig !== 1'b0 || busy !== 1'b0 || prd_cmplt !== 1'b0) act++;
      end
      chk("post_rst_quiet", act, 0);

      // Shadow was cleared by reset
      pulse_strt;
      chk("post_rst_duty_cur", duty_cur, 0);
      run_period(-1, '0, -1, h, c, pc, pp, md, mb);
      chk("post_rst_highs", h, 0);
      chk("post_rst_prd_cnt", pc, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
